// File: rtl/unified_pipe_control.sv
// Decode stage with ID/EX register for the ARMv8-lite pipe: decodes the
// instruction word into control/immediate/register fields, detects load-use
// hazards against the instruction in ID/EX, injects bubbles on stall, flush,
// idle or illegal opcode, and counts stall/flush events with saturation.
module unified_pipe_control #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instruction,
  input  logic              flush,
  output logic              ready,
  output logic              ex_valid,
  output logic [11:0]       ex_ctrl,
  output logic [2:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rn,
  output logic [4:0]        ex_rm,
  output logic [4:0]        ex_rd,
  output logic [3:0]        ex_cond,
  output logic              illegal,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  // ex_ctrl bit positions, MSB first
  localparam int CReg2Loc  = 11;
  localparam int CUncond   = 10;
  localparam int CBranch   = 9;
  localparam int CMemtoReg = 8;
  localparam int CMemRead  = 7;
  localparam int CMemWrite = 6;
  localparam int CAluSrc   = 5;
  localparam int CRegWrite = 4;
  localparam int CLink     = 3;
  localparam int CBReg     = 2;
  localparam int CBranch0  = 1;
  localparam int CSetFlag  = 0;

  logic              dec_legal;
  logic              dec_uses_rm;
  logic [11:0]       dec_ctrl;
  logic [2:0]        dec_aluop;
  logic [DATA_W-1:0] dec_imm;
  logic [4:0]        dec_rn, dec_rm, dec_rd;
  logic              hazard;

  logic              ex_valid_q, ex_valid_d;
  logic [11:0]       ex_ctrl_q, ex_ctrl_d;
  logic [2:0]        ex_aluop_q, ex_aluop_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]        ex_rn_q, ex_rn_d, ex_rm_q, ex_rm_d, ex_rd_q, ex_rd_d;
  logic [3:0]        ex_cond_q, ex_cond_d;
  logic              illegal_q, illegal_d;
  logic [CNT_W-1:0]  stall_q, stall_d, flushc_q, flushc_d;

  // Opcode decode: control bits, ALU op, extended immediate, rm usage
  always_comb begin
    dec_legal   = 1'b1;
    dec_uses_rm = 1'b0;
    dec_ctrl    = '0;
    dec_aluop   = 3'b000;
    dec_imm     = '0;
    if (instruction[31:22] == 10'b1001000100) begin         // ADDI
      dec_ctrl[CAluSrc]   = 1'b1;
      dec_ctrl[CRegWrite] = 1'b1;
      dec_aluop           = 3'b010;
      dec_imm             = {{(DATA_W-12){1'b0}}, instruction[21:10]};
    end else if (instruction[31:21] == 11'b11111000010) begin // LDUR
      dec_ctrl[CAluSrc]   = 1'b1;
      dec_ctrl[CMemtoReg] = 1'b1;
      dec_ctrl[CRegWrite] = 1'b1;
      dec_ctrl[CMemRead]  = 1'b1;
      dec_aluop           = 3'b010;
      dec_imm             = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
    end else if (instruction[31:21] == 11'b11111000000) begin // STUR
      dec_ctrl[CReg2Loc]  = 1'b1;
      dec_ctrl[CAluSrc]   = 1'b1;
      dec_ctrl[CMemWrite] = 1'b1;
      dec_aluop           = 3'b010;
      dec_uses_rm         = 1'b1;
      dec_imm             = {{(DATA_W-9){instruction[20]}}, instruction[20:12]};
    end else if (instruction[31:21] == 11'b10101011000) begin // ADDS
      dec_ctrl[CRegWrite] = 1'b1;
      dec_ctrl[CSetFlag]  = 1'b1;
      dec_aluop           = 3'b010;
      dec_uses_rm         = 1'b1;
    end else if (instruction[31:21] == 11'b11101011000) begin // SUBS
      dec_ctrl[CRegWrite] = 1'b1;
      dec_ctrl[CSetFlag]  = 1'b1;
      dec_aluop           = 3'b011;
      dec_uses_rm         = 1'b1;
    end else if (instruction[31:10] == 22'b1101011000011111000000) begin // BR
      dec_ctrl[CUncond]   = 1'b1;
      dec_ctrl[CBReg]     = 1'b1;
    end else if (instruction[31:24] == 8'b10110100) begin   // CBZ
      dec_ctrl[CReg2Loc]  = 1'b1;
      dec_ctrl[CBranch]   = 1'b1;
      dec_ctrl[CBranch0]  = 1'b1;
      dec_uses_rm         = 1'b1;
      dec_imm             = {{(DATA_W-19){instruction[23]}}, instruction[23:5]};
    end else if (instruction[31:24] == 8'b01010100) begin   // B.cond
      dec_ctrl[CBranch]   = 1'b1;
      dec_imm             = {{(DATA_W-19){instruction[23]}}, instruction[23:5]};
    end else if (instruction[31:26] == 6'b000101) begin     // B
      dec_ctrl[CUncond]   = 1'b1;
      dec_imm             = {{(DATA_W-26){instruction[25]}}, instruction[25:0]};
    end else if (instruction[31:26] == 6'b100101) begin     // BL
      dec_ctrl[CUncond]   = 1'b1;
      dec_ctrl[CRegWrite] = 1'b1;
      dec_ctrl[CLink]     = 1'b1;
      dec_imm             = {{(DATA_W-26){instruction[25]}}, instruction[25:0]};
    end else begin
      dec_legal = 1'b0;
    end
  end

  assign dec_rn = instruction[9:5];
  assign dec_rm = dec_ctrl[CReg2Loc] ? instruction[4:0] : instruction[20:16];
  assign dec_rd = dec_ctrl[CLink] ? 5'd30 : instruction[4:0];

  // Load-use hazard against the load currently in ID/EX (x31 never hazards)
  assign hazard = instr_valid && ex_valid_q && ex_ctrl_q[CMemRead] && (ex_rd_q != 5'd31) &&
                  ((dec_rn == ex_rd_q) || (dec_uses_rm && (dec_rm == ex_rd_q)));

  // Flush overrides the stall
  assign ready = !(hazard && !flush);

  // ID/EX next state: bubble by default, load only on clean accept
  always_comb begin
    ex_valid_d = 1'b0;
    ex_ctrl_d  = '0;
    ex_aluop_d = '0;
    ex_imm_d   = '0;
    ex_rn_d    = '0;
    ex_rm_d    = '0;
    ex_rd_d    = '0;
    ex_cond_d  = '0;
    illegal_d  = 1'b0;
    if (!flush && instr_valid && !hazard) begin
      if (dec_legal) begin
        ex_valid_d = 1'b1;
        ex_ctrl_d  = dec_ctrl;
        ex_aluop_d = dec_aluop;
        ex_imm_d   = dec_imm;
        ex_rn_d    = dec_rn;
        ex_rm_d    = dec_rm;
        ex_rd_d    = dec_rd;
        ex_cond_d  = instruction[3:0];
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  // Saturating event counters
  always_comb begin
    stall_d  = stall_q;
    flushc_d = flushc_q;
    if (hazard && !flush && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (flush && (flushc_q != '1))           flushc_d = flushc_q + CNT_W'(1);
  end

  // ID/EX register and counters, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_aluop_q <= '0;
      ex_imm_q   <= '0;
      ex_rn_q    <= '0;
      ex_rm_q    <= '0;
      ex_rd_q    <= '0;
      ex_cond_q  <= '0;
      illegal_q  <= 1'b0;
      stall_q    <= '0;
      flushc_q   <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_aluop_q <= ex_aluop_d;
      ex_imm_q   <= ex_imm_d;
      ex_rn_q    <= ex_rn_d;
      ex_rm_q    <= ex_rm_d;
      ex_rd_q    <= ex_rd_d;
      ex_cond_q  <= ex_cond_d;
      illegal_q  <= illegal_d;
      stall_q    <= stall_d;
      flushc_q   <= flushc_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_aluop    = ex_aluop_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rn       = ex_rn_q;
  assign ex_rm       = ex_rm_q;
  assign ex_rd       = ex_rd_q;
  assign ex_cond     = ex_cond_q;
  assign illegal     = illegal_q;
  assign stall_count = stall_q;
  assign flush_count = flushc_q;

endmodule

// File: tb/tb_unified_pipe_control.sv
// Scoreboard bench for unified_pipe_control: a reference model predicts the
// ID/EX contents after every edge and a negedge monitor compares them.
module tb_unified_pipe_control;

  localparam int C_R2L = 11, C_UNC = 10, C_BR = 9, C_M2R = 8, C_MRD = 7, C_MWR = 6;
  localparam int C_ASRC = 5, C_RW = 4, C_LNK = 3, C_BREG = 2, C_B0 = 1, C_SF = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instruction = '0;
  logic        flush = 1'b0;
  logic        ready, ex_valid, illegal;
  logic [11:0] ex_ctrl;
  logic [2:0]  ex_aluop;
  logic [63:0] ex_imm;
  logic [4:0]  ex_rn, ex_rm, ex_rd;
  logic [3:0]  ex_cond;
  logic [15:0] stall_count, flush_count;

  logic        rst2 = 1'b0;
  logic        fl2 = 1'b0;
  logic        iv2 = 1'b0;
  logic [31:0] instr2 = '0;
  logic        ready2, exv2, ill2;
  logic [11:0] ctrl2;
  logic [2:0]  aluop2;
  logic [63:0] imm2;
  logic [4:0]  rn2, rm2, rd2;
  logic [3:0]  cond2;
  logic [1:0]  sc2, fc2;

  always #5 clk = ~clk;

  unified_pipe_control dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .flush(flush), .ready(ready), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_aluop(ex_aluop), .ex_imm(ex_imm), .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd),
    .ex_cond(ex_cond), .illegal(illegal), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  unified_pipe_control #(.DATA_W(64), .CNT_W(2)) dut2 (
    .clk(clk), .reset(rst2), .instr_valid(iv2), .instruction(instr2), .flush(fl2),
    .ready(ready2), .ex_valid(exv2), .ex_ctrl(ctrl2), .ex_aluop(aluop2), .ex_imm(imm2),
    .ex_rn(rn2), .ex_rm(rm2), .ex_rd(rd2), .ex_cond(cond2), .illegal(ill2),
    .stall_count(sc2), .flush_count(fc2)
  );

  typedef struct packed {
    logic        v;
    logic [11:0] ctrl;
    logic [2:0]  aluop;
    logic [63:0] imm;
    logic [4:0]  rn, rm, rd;
    logic [3:0]  cond;
    logic        ill;
    logic [15:0] sc, fc;
  } exp_t;

  typedef struct packed {
    logic        legal;
    logic        uses_rm;
    logic [11:0] ctrl;
    logic [2:0]  aluop;
    logic [63:0] imm;
    logic [4:0]  rn, rm, rd;
  } dec_t;

  exp_t q[$];
  exp_t m;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Two's-complement value of the low n bits of v, as a 64-bit pattern
  function automatic logic [63:0] sext(input logic [31:0] v, input int n);
    longint unsigned x;
    x = longint'(v) & ((64'd1 << n) - 64'd1);
    if (x >= (64'd1 << (n - 1))) x = x - (64'd1 << n);
    return x;
  endfunction

  // Reference decode: classify by opcode, then apply the per-instruction table
  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    d.rn = w[9:5];
    if (w[31:22] == 10'h244) begin
      d.ctrl[C_ASRC] = 1; d.ctrl[C_RW] = 1; d.aluop = 3'd2; d.imm = 64'(w[21:10]);
    end else if (w[31:21] == 11'h7C2) begin
      d.ctrl[C_ASRC] = 1; d.ctrl[C_M2R] = 1; d.ctrl[C_RW] = 1; d.ctrl[C_MRD] = 1;
      d.aluop = 3'd2; d.imm = sext(32'(w[20:12]), 9);
    end else if (w[31:21] == 11'h7C0) begin
      d.ctrl[C_R2L] = 1; d.ctrl[C_ASRC] = 1; d.ctrl[C_MWR] = 1;
      d.aluop = 3'd2; d.imm = sext(32'(w[20:12]), 9); d.uses_rm = 1;
    end else if (w[31:21] == 11'h558) begin
      d.ctrl[C_RW] = 1; d.ctrl[C_SF] = 1; d.aluop = 3'd2; d.uses_rm = 1;
    end else if (w[31:21] == 11'h758) begin
      d.ctrl[C_RW] = 1; d.ctrl[C_SF] = 1; d.aluop = 3'd3; d.uses_rm = 1;
    end else if (w[31:10] == 22'h3587C0) begin
      d.ctrl[C_UNC] = 1; d.ctrl[C_BREG] = 1;
    end else if (w[31:24] == 8'hB4) begin
      d.ctrl[C_R2L] = 1; d.ctrl[C_BR] = 1; d.ctrl[C_B0] = 1; d.uses_rm = 1;
      d.imm = sext(32'(w[23:5]), 19);
    end else if (w[31:24] == 8'h54) begin
      d.ctrl[C_BR] = 1; d.imm = sext(32'(w[23:5]), 19);
    end else if (w[31:26] == 6'b000101) begin
      d.ctrl[C_UNC] = 1; d.imm = sext(32'(w[25:0]), 26);
    end else if (w[31:26] == 6'b100101) begin
      d.ctrl[C_UNC] = 1; d.ctrl[C_RW] = 1; d.ctrl[C_LNK] = 1; d.imm = sext(32'(w[25:0]), 26);
    end else begin
      d.legal = 1'b0;
    end
    d.rm = d.ctrl[C_R2L] ? w[4:0] : w[20:16];
    d.rd = d.ctrl[C_LNK] ? 5'd30 : w[4:0];
    return d;
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] c);
    return (int'(c) + 1 > 65535) ? 16'hFFFF : c + 16'd1;
  endfunction

  // One decode cycle: drive, check ready, predict and push the post-edge state
  task automatic step(input logic iv, input logic [31:0] w, input logic fl, output logic rdy);
    exp_t nx;
    dec_t d;
    logic hz;
    instr_valid = iv;
    instruction = w;
    flush = fl;
    d = decode(w);
    hz = iv && m.v && m.ctrl[C_MRD] && (m.rd != 5'd31) &&
         (d.rn == m.rd || (d.uses_rm && d.rm == m.rd));
    rdy = !(hz && !fl);
    #1;
    chk("ready", 64'(ready), 64'(rdy));
    nx = '0;
    nx.sc = m.sc;
    nx.fc = m.fc;
    if (fl) nx.fc = sat16(m.fc);
    else if (iv) begin
      if (hz) nx.sc = sat16(m.sc);
      else if (!d.legal) nx.ill = 1'b1;
      else begin
        nx.v = 1'b1; nx.ctrl = d.ctrl; nx.aluop = d.aluop; nx.imm = d.imm;
        nx.rn = d.rn; nx.rm = d.rm; nx.rd = d.rd; nx.cond = w[3:0];
      end
    end
    @(posedge clk);
    m = nx;
    q.push_back(nx);
    #6;
  endtask

  // Monitor: compare the DUT against each predicted ID/EX state
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ex_valid", 64'(ex_valid), 64'(e.v));
      chk("ex_ctrl", 64'(ex_ctrl), 64'(e.ctrl));
      chk("ex_aluop", 64'(ex_aluop), 64'(e.aluop));
      chk("ex_imm", ex_imm, e.imm);
      chk("ex_regs", 64'({ex_rn, ex_rm, ex_rd}), 64'({e.rn, e.rm, e.rd}));
      chk("ex_cond", 64'(ex_cond), 64'(e.cond));
      chk("illegal", 64'(illegal), 64'(e.ill));
      chk("counters", 64'({stall_count, flush_count}), 64'({e.sc, e.fc}));
    end
  end

  function automatic logic [4:0] rreg();
    int p;
    p = $urandom_range(0, 3);
    return (p == 3) ? 5'd31 : 5'(p);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 10))
      0:  return {10'h244, r[21:10], rreg(), rreg()};
      1:  return {11'h7C2, r[20:12], 2'b00, rreg(), rreg()};
      2:  return {11'h7C0, r[20:12], 2'b00, rreg(), rreg()};
      3:  return {11'h558, rreg(), 6'd0, rreg(), rreg()};
      4:  return {11'h758, rreg(), 6'd0, rreg(), rreg()};
      5:  return {8'hB4, r[23:5], rreg()};
      6:  return {8'h54, r[23:5], r[4:0]};
      7:  return {6'b000101, r[25:0]};
      8:  return {6'b100101, r[25:0]};
      9:  return {22'h3587C0, rreg(), 5'd0};
      default: return r;
    endcase
  endfunction

  localparam logic [31:0] LDUR_W  = 32'hF8408041;
  localparam logic [31:0] ADDS_W  = 32'hAB040023;
  localparam logic [31:0] BCOND_W = 32'h54FFFFE1;
  localparam logic [31:0] ADDI_W  = 32'h913FFC00;

  initial begin
    logic        rdy;
    logic        hold;
    logic [31:0] w;
    logic        iv, fl;
    m = '0;
    #1 reset = 1'b1;
    #1;
    chk("reset_state", 64'({ex_valid, ex_ctrl, ex_aluop, illegal, ex_rn, ex_rm, ex_rd, ex_cond}),
        64'd0);
    chk("reset_imm_cnt", ex_imm | 64'({stall_count, flush_count}), 64'd0);
    chk("reset_ready", 64'(ready), 64'd1);
    @(posedge clk);
    #6;
    reset = 1'b0;

    // Load-use stall then issue of the dependent ADDS
    step(1'b1, LDUR_W, 1'b0, rdy);
    step(1'b1, ADDS_W, 1'b0, rdy);
    chk("stall_ready", 64'(rdy), 64'd0);
    chk("stall_bubble", 64'(ex_valid), 64'd0);
    chk("stall_count", 64'(stall_count), 64'd1);
    step(1'b1, ADDS_W, 1'b0, rdy);
    chk("adds_regs", 64'({ex_rn, ex_rm, ex_rd}), 64'({5'd1, 5'd4, 5'd3}));
    chk("adds_setflag", 64'(ex_ctrl[C_SF]), 64'd1);
    chk("adds_aluop", 64'(ex_aluop), 64'd2);

    step(1'b1, BCOND_W, 1'b0, rdy);
    chk("bcond_branch", 64'(ex_ctrl[C_BR]), 64'd1);
    chk("bcond_cond", 64'(ex_cond), 64'd1);
    chk("bcond_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);

    step(1'b1, ADDI_W, 1'b0, rdy);
    chk("addi_imm", ex_imm, 64'hFFF);
    chk("addi_ctrl", 64'({ex_ctrl[C_ASRC], ex_ctrl[C_RW], ex_aluop}), 64'({2'b11, 3'b010}));

    // Hazard and flush together: flush wins
    step(1'b1, LDUR_W, 1'b0, rdy);
    step(1'b1, ADDS_W, 1'b1, rdy);
    chk("flushhz_ready", 64'(rdy), 64'd1);
    chk("flushhz_counts", 64'({stall_count, flush_count}), 64'({16'd1, 16'd1}));

    // Illegal opcode pulses for exactly one cycle
    step(1'b1, 32'h0, 1'b0, rdy);
    chk("illegal_pulse", 64'({ex_valid, illegal}), 64'({1'b0, 1'b1}));
    step(1'b0, 32'h0, 1'b0, rdy);
    chk("illegal_clear", 64'(illegal), 64'd0);

    // Reset during a stall clears the hazard
    step(1'b1, LDUR_W, 1'b0, rdy);
    instr_valid = 1'b1;
    instruction = ADDS_W;
    flush = 1'b0;
    #1;
    chk("midstall_ready", 64'(ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("midrst_clear", 64'({ready, ex_valid, stall_count}), 64'({1'b1, 1'b0, 16'd0}));
    reset = 1'b0;
    m = '0;
    step(1'b1, ADDS_W, 1'b0, rdy);
    chk("midrst_issue", 64'(ex_valid), 64'd1);

    // Randomised traffic; a stalled instruction is held until accepted
    hold = 1'b0;
    w = '0;
    iv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        w = rand_instr();
        iv = ($urandom_range(0, 99) < 85);
      end
      fl = ($urandom_range(0, 99) < 10);
      step(iv, w, fl, rdy);
      hold = !rdy;
    end
    instr_valid = 1'b0;
    flush = 1'b0;

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    // Two-bit counter saturation and asynchronous reset on the second instance
    rst2 = 1'b1;
    #1 rst2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fl2 = 1'b1;
      @(posedge clk);
      #6;
      chk("sat_flush_count", 64'(fc2), 64'((i + 1 > 3) ? 3 : i + 1));
    end
    fl2 = 1'b0;
    #1 rst2 = 1'b1;
    #1;
    chk("sat_reset", 64'({exv2, ctrl2, aluop2, ill2, rn2, rm2, rd2, cond2, sc2, fc2}), 64'd0);
    chk("sat_reset_imm", imm2, 64'd0);
    chk("sat_reset_ready", 64'(ready2), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
